// File: rtl/dar_router_param.sv
// dar_router_param: parametrised NUM_CH x NUM_CH audio router.
// Each output k has a source select and a mute bit held in the active map.
// The map is reloaded from a serial frame captured while prgrm_go_ is low.
// A frame is committed only when its length is exactly FRM_BITS and its
// overall parity is even; otherwise err_ drops and the old map is kept.
// The datapath has no handshake: di is sampled every edge and do follows
// one cycle later through the active map.
// Note: the routed-output port is named dout because "do" is a reserved word.
module dar_router_param #(
    parameter  int NUM_CH   = 4,
    parameter  int DATA_W   = 16,
    localparam int SEL_W    = $clog2(NUM_CH),
    localparam int FRM_BITS = NUM_CH * (SEL_W + 1) + 1
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic [NUM_CH*DATA_W-1:0]   di,
    output logic [NUM_CH*DATA_W-1:0]   dout,
    input  logic                       prgrm_in,
    input  logic                       prgrm_go_,
    output logic                       err_,
    output logic                       map_valid,
    output logic                       o_state
);

    localparam int            CNT_W   = $clog2(FRM_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(FRM_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(FRM_BITS);
    localparam int            FLD_W   = SEL_W + 1;

    // The length/parity check happens on the edge that leaves PROG, so no
    // separate CHECK state is ever occupied.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PROG = 1'b1
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [FRM_BITS-1:0]    r_sr;
    logic [SEL_W-1:0]       r_sel  [NUM_CH];
    logic [NUM_CH-1:0]      r_mute;
    logic                   r_err_n;
    logic                   r_map_valid;
    logic [NUM_CH*DATA_W-1:0] r_do;

    logic [DATA_W-1:0]      w_di_ch [NUM_CH];
    logic                   w_frame_ok;

    // Unpack the input bus so the router can index channels by select value.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign w_di_ch[g] = di[g*DATA_W +: DATA_W];
    end

    // Frame is good when exactly FRM_BITS bits arrived and the ones count is even.
    // The first arrived bit ends up in r_sr[0], the parity bit in the MSB.
    assign w_frame_ok = (r_cnt == CNT_LEN) && !(^r_sr);

    // Programming FSM: capture serial frame, check it on exit, commit the map.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_sr        <= '0;
            r_err_n     <= 1'b1;
            r_map_valid <= 1'b0;
            r_mute      <= '1;
            for (int k = 0; k < NUM_CH; k++) begin
                r_sel[k] <= SEL_W'(k);
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!prgrm_go_) begin
                        r_state <= ST_PROG;
                        r_err_n <= 1'b1;
                        r_cnt   <= CNT_W'(1);
                        r_sr    <= {prgrm_in, {(FRM_BITS-1){1'b0}}};
                    end
                end
                ST_PROG: begin
                    if (!prgrm_go_) begin
                        // Once saturated the frame is already too long; drop extra bits.
                        if (r_cnt != CNT_SAT) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                            r_sr  <= {prgrm_in, r_sr[FRM_BITS-1:1]};
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        if (w_frame_ok) begin
                            r_map_valid <= 1'b1;
                            for (int k = 0; k < NUM_CH; k++) begin
                                r_sel[k]  <= r_sr[k*FLD_W +: SEL_W];
                                r_mute[k] <= r_sr[k*FLD_W + SEL_W];
                            end
                        end else begin
                            r_err_n <= 1'b0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Router: each output registers its selected (or muted) source sample.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_do <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_do[k*DATA_W +: DATA_W] <= r_mute[k] ? '0 : w_di_ch[r_sel[k]];
            end
        end
    end

    assign dout      = r_do;
    assign err_      = r_err_n;
    assign map_valid = r_map_valid;
    assign o_state   = r_state;

endmodule
